// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC defaults, the fetch FSM encoding, the NOP
// encoding and a word-alignment helper for instruction addresses.
package cpu_pkg;

    localparam int          INST_W         = 32;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0180;
    localparam logic [31:0] NOP_INST       = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Instruction addresses are always word aligned; drop the byte offset.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, flush and load controls.
// Priority: rst > flush > hold > load. A flushed or invalid slot always
// carries NOP_INST so decode sees a harmless instruction.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              load,
    input  logic [31:0]       pc_in,
    input  logic [INST_W-1:0] inst_in,
    input  logic              valid_in,
    output logic [31:0]       id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid
);

    // Pipeline register update: reset, squash, or capture a new slot.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc    <= '0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (load && !hold) begin
            id_pc    <= pc_in;
            id_inst  <= valid_in ? inst_in : NOP_INST;
            id_valid <= valid_in;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC and fetch FSM, drives the
// instruction memory, and loads the IF/ID register.
// Optional build macro IF_DELAY_SLOT_EN: when defined, the instruction
// fetched alongside a taken branch (the delay slot) is kept valid; when
// undefined, that slot is squashed to a NOP.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [31:0]       branch_target_i,
    input  logic              exc_flag_i,
    output logic              inst_ce_o,
    output logic [31:0]       inst_addr_o,
    input  logic [INST_W-1:0] inst_data_i,
    output logic [31:0]       id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o
);

    fetch_state_t state, next_state;
    logic [31:0]  pc, pc_next;
    logic         ifid_load;
    logic         ifid_flush;
    logic         slot_valid;

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            pc    <= pc_next;
        end
    end

    // Next-state, next-PC and IF/ID controls; exception beats stall beats branch.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        pc_next    = pc;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        slot_valid = 1'b1;
        case (state)
            IDLE: begin
                next_state = FETCH;
            end
            FETCH, HOLD: begin
                if (exc_flag_i) begin
                    pc_next    = word_align(EXC_VECTOR);
                    ifid_flush = 1'b1;
                    next_state = FETCH;
                end else if (stall_i) begin
                    next_state = HOLD;
                end else if (state == HOLD) begin
                    // Resume at the held PC; the IF/ID slot is refilled next edge.
                    next_state = FETCH;
                end else begin
                    ifid_load = 1'b1;
                    pc_next   = branch_flag_i ? word_align(branch_target_i) : pc + 32'd4;
`ifdef IF_DELAY_SLOT_EN
                    slot_valid = 1'b1;
`else
                    slot_valid = !branch_flag_i;
`endif
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign inst_ce_o   = (state == FETCH);
    assign inst_addr_o = pc;

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .hold     (stall_i),
        .flush    (ifid_flush),
        .load     (ifid_load),
        .pc_in    (pc),
        .inst_in  (inst_data_i),
        .valid_in (slot_valid),
        .id_pc    (id_pc_o),
        .id_inst  (id_inst_o),
        .id_valid (id_valid_o)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage. A behavioural model predicts the
// fetch outputs and IF/ID contents for every edge and pushes them to a
// scoreboard; a negedge monitor pops and compares. Scenario tasks add
// directed checks against hand-derived constants.
module tb_if_fetch_stage;

    localparam int S_IDLE  = 0;
    localparam int S_FETCH = 1;
    localparam int S_HOLD  = 2;

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] id_pc;
        logic [31:0] id_inst;
        logic        id_valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        exc_flag_i = 1'b0;
    logic        inst_ce_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_data_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];

    int          m_st = S_IDLE;
    logic [31:0] m_pc = '0;
    logic [31:0] m_id_pc = '0;
    logic [31:0] m_id_inst = '0;
    logic        m_id_valid = 1'b0;

    if_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .exc_flag_i      (exc_flag_i),
        .inst_ce_o       (inst_ce_o),
        .inst_addr_o     (inst_addr_o),
        .inst_data_i     (inst_data_i),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory: tagged address, zero when disabled.
    assign inst_data_i = inst_ce_o ? (32'h1000_0000 | inst_addr_o) : 32'h0;

    // Advance one edge: model the edge from the current inputs, then push.
    task automatic advance();
        logic [31:0] d;
        d = 32'h1000_0000 | m_pc;
        if (rst) begin
            m_st = S_IDLE; m_pc = 32'h0;
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
        end else if (m_st == S_IDLE) begin
            m_st = S_FETCH;
        end else if (exc_flag_i) begin
            m_pc = 32'h0000_0180; m_id_inst = 32'h0; m_id_valid = 1'b0; m_st = S_FETCH;
        end else if (stall_i) begin
            m_st = S_HOLD;
        end else if (m_st == S_HOLD) begin
            m_st = S_FETCH;
        end else begin
            m_id_pc = m_pc;
            if (branch_flag_i) begin
`ifdef IF_DELAY_SLOT_EN
                m_id_inst = d; m_id_valid = 1'b1;
`else
                m_id_inst = 32'h0; m_id_valid = 1'b0;
`endif
                m_pc = {branch_target_i[31:2], 2'b00};
            end else begin
                m_id_inst = d; m_id_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        sb.push_back('{ce: (m_st == S_FETCH), addr: m_pc, id_pc: m_id_pc,
                       id_inst: m_id_inst, id_valid: m_id_valid});
    endtask

    // Scoreboard monitor: compare each predicted cycle mid-period.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++; if (inst_ce_o !== e.ce) begin bad++; $display("FAIL sb_ce t=%0t got=%b exp=%b", $time, inst_ce_o, e.ce); end
            total++; if (inst_addr_o !== e.addr) begin bad++; $display("FAIL sb_addr t=%0t got=%h exp=%h", $time, inst_addr_o, e.addr); end
            total++; if (id_pc_o !== e.id_pc) begin bad++; $display("FAIL sb_id_pc t=%0t got=%h exp=%h", $time, id_pc_o, e.id_pc); end
            total++; if (id_inst_o !== e.id_inst) begin bad++; $display("FAIL sb_id_inst t=%0t got=%h exp=%h", $time, id_inst_o, e.id_inst); end
            total++; if (id_valid_o !== e.id_valid) begin bad++; $display("FAIL sb_id_valid t=%0t got=%b exp=%b", $time, id_valid_o, e.id_valid); end
        end
    end

    // Reset then release; afterwards the FSM is in IDLE with ce=0.
    task automatic do_reset();
        stall_i = 0; branch_flag_i = 0; exc_flag_i = 0;
        rst = 1;
        repeat (3) advance();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (inst_ce_o !== 1'b0) begin bad++; $display("FAIL reset_ce_idle got=%b exp=0", inst_ce_o); end
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid_o); end
        advance();
        total++; if (inst_ce_o !== 1'b1) begin bad++; $display("FAIL reset_first_ce got=%b exp=1", inst_ce_o); end
        total++; if (inst_addr_o !== 32'h0) begin bad++; $display("FAIL reset_first_addr got=%h exp=0", inst_addr_o); end
        advance();
        total++; if (id_pc_o !== 32'h0) begin bad++; $display("FAIL reset_id_pc got=%h exp=0", id_pc_o); end
        total++; if (id_inst_o !== 32'h1000_0000) begin bad++; $display("FAIL reset_id_inst got=%h exp=10000000", id_inst_o); end
        total++; if (id_valid_o !== 1'b1) begin bad++; $display("FAIL reset_id_valid got=%b exp=1", id_valid_o); end
        total++; if (inst_addr_o !== 32'h4) begin bad++; $display("FAIL reset_next_addr got=%h exp=4", inst_addr_o); end
    endtask

    // Continues from test_reset: IF/ID holds pc 0, addr is 4.
    task automatic test_sequential();
        for (int i = 1; i < 4; i++) begin
            advance();
            total++; if (id_pc_o !== 32'(4 * i)) begin bad++; $display("FAIL seq_id_pc i=%0d got=%h exp=%h", i, id_pc_o, 32'(4 * i)); end
            total++; if (id_inst_o !== (32'h1000_0000 | 32'(4 * i))) begin bad++; $display("FAIL seq_id_inst i=%0d got=%h", i, id_inst_o); end
            total++; if (id_valid_o !== 1'b1) begin bad++; $display("FAIL seq_valid i=%0d got=%b exp=1", i, id_valid_o); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) advance();          // addr=8, IF/ID pc=4
        stall_i = 1;
        advance();
        total++; if (inst_ce_o !== 1'b0) begin bad++; $display("FAIL stall_ce got=%b exp=0", inst_ce_o); end
        total++; if (id_pc_o !== 32'h4) begin bad++; $display("FAIL stall_hold_pc got=%h exp=4", id_pc_o); end
        advance();
        total++; if (inst_addr_o !== 32'h8) begin bad++; $display("FAIL stall_addr got=%h exp=8", inst_addr_o); end
        stall_i = 0;
        advance();
        total++; if (inst_ce_o !== 1'b1) begin bad++; $display("FAIL stall_resume_ce got=%b exp=1", inst_ce_o); end
        total++; if (inst_addr_o !== 32'h8) begin bad++; $display("FAIL stall_resume_addr got=%h exp=8", inst_addr_o); end
        total++; if (id_pc_o !== 32'h4) begin bad++; $display("FAIL stall_resume_id got=%h exp=4", id_pc_o); end
        advance();
        total++; if (id_pc_o !== 32'h8) begin bad++; $display("FAIL stall_after_id got=%h exp=8", id_pc_o); end
        total++; if (inst_addr_o !== 32'hC) begin bad++; $display("FAIL stall_after_addr got=%h exp=c", inst_addr_o); end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (5) advance();          // addr=0x10
        branch_flag_i = 1; branch_target_i = 32'h0000_0043;
        advance();
        branch_flag_i = 0;
        total++; if (inst_addr_o !== 32'h40) begin bad++; $display("FAIL br_addr got=%h exp=40", inst_addr_o); end
        total++; if (id_pc_o !== 32'h10) begin bad++; $display("FAIL br_id_pc got=%h exp=10", id_pc_o); end
`ifdef IF_DELAY_SLOT_EN
        total++; if (id_valid_o !== 1'b1) begin bad++; $display("FAIL br_slot_valid got=%b exp=1", id_valid_o); end
        total++; if (id_inst_o !== 32'h1000_0010) begin bad++; $display("FAIL br_slot_inst got=%h exp=10000010", id_inst_o); end
`else
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL br_slot_valid got=%b exp=0", id_valid_o); end
        total++; if (id_inst_o !== 32'h0) begin bad++; $display("FAIL br_slot_inst got=%h exp=0", id_inst_o); end
`endif
        advance();
        total++; if (id_pc_o !== 32'h40) begin bad++; $display("FAIL br_target_id got=%h exp=40", id_pc_o); end
    endtask

    task automatic test_exception();
        stall_i = 1; branch_flag_i = 1; branch_target_i = 32'h0000_0500; exc_flag_i = 1;
        advance();
        stall_i = 0; branch_flag_i = 0; exc_flag_i = 0;
        total++; if (inst_addr_o !== 32'h180) begin bad++; $display("FAIL exc_addr got=%h exp=180", inst_addr_o); end
        total++; if (inst_ce_o !== 1'b1) begin bad++; $display("FAIL exc_ce got=%b exp=1", inst_ce_o); end
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL exc_valid got=%b exp=0", id_valid_o); end
        total++; if (id_inst_o !== 32'h0) begin bad++; $display("FAIL exc_inst got=%h exp=0", id_inst_o); end
        advance();
        total++; if (id_inst_o !== 32'h1000_0180) begin bad++; $display("FAIL exc_vec_inst got=%h exp=10000180", id_inst_o); end
    endtask

    task automatic test_wrap();
        branch_flag_i = 1; branch_target_i = 32'hFFFF_FFFF;
        advance();
        branch_flag_i = 0;
        total++; if (inst_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_target got=%h exp=fffffffc", inst_addr_o); end
        advance();
        total++; if (inst_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", inst_addr_o); end
        total++; if (id_pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_id_pc got=%h exp=fffffffc", id_pc_o); end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        repeat (9) advance();          // addr=0x20
        total++; if (inst_addr_o !== 32'h20) begin bad++; $display("FAIL mid_pre_addr got=%h exp=20", inst_addr_o); end
        rst = 1;
        advance();
        rst = 0;
        total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", id_valid_o); end
        total++; if (inst_ce_o !== 1'b0) begin bad++; $display("FAIL mid_ce got=%b exp=0", inst_ce_o); end
        advance();
        total++; if (inst_addr_o !== 32'h0) begin bad++; $display("FAIL mid_restart_addr got=%h exp=0", inst_addr_o); end
        advance();
        total++; if (id_pc_o !== 32'h0 || id_valid_o !== 1'b1) begin bad++; $display("FAIL mid_restart_id got=%h/%b exp=0/1", id_pc_o, id_valid_o); end
    endtask

    // Random mix of stalls, branches, exceptions and resets, model-checked.
    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            rst             = ($urandom_range(0, 79) == 0);
            stall_i         = ($urandom_range(0, 3) == 0);
            branch_flag_i   = ($urandom_range(0, 4) == 0);
            branch_target_i = $urandom;
            exc_flag_i      = ($urandom_range(0, 22) == 0);
            advance();
        end
        rst = 0; stall_i = 0; branch_flag_i = 0; exc_flag_i = 0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_exception();
        test_wrap();
        test_midrun_reset();
        test_back_to_back();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
